// File: rtl/replication_pkg.sv
// Shared defaults and the majority-vote helper for the replicated-field format.
package replication_pkg;
  localparam int W     = 3;
  localparam int N1    = 4;
  localparam int N2    = 2;
  localparam int Y1W   = 16;
  localparam int Y2W   = 32;
  localparam int CNT_W = 16;

  localparam int MAX_W = 16;
  localparam int MAX_N = 16;

  // Copy k lives at copies[k*w +: w]; a bit that ties across copies is taken from copy 0.
  function automatic logic [MAX_W-1:0] maj_vote(input logic [MAX_N*MAX_W-1:0] copies,
                                                 input int n, input int w);
    logic [MAX_W-1:0] r;
    int ones;
    r = '0;
    for (int b = 0; b < MAX_W; b++) begin
      ones = 0;
      for (int k = 0; k < MAX_N; k++)
        if (k < n && b < w) ones = ones + int'(copies[k*w+b]);
      if (b < w) begin
        if (2*ones > n)       r[b] = 1'b1;
        else if (2*ones == n) r[b] = copies[b];
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/replication_unpacker_check.sv
// Combinational decode of one (y1,y2) word: voted A, copy-0 B, and consistency/padding flags.
module replica_check #(
  parameter int W   = replication_pkg::W,
  parameter int N1  = replication_pkg::N1,
  parameter int N2  = replication_pkg::N2,
  parameter int Y1W = replication_pkg::Y1W,
  parameter int Y2W = replication_pkg::Y2W
) (
  input  logic [Y1W-1:0] y1,
  input  logic [Y2W-1:0] y2,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  output logic           a_err,
  output logic           b_err,
  output logic           pad_err
);
  import replication_pkg::*;

  logic [MAX_N*MAX_W-1:0] cp;
  logic [MAX_W-1:0]       voted;
  logic [W-1:0]           a0, b0;
  logic [N1-1:0]          a1_mis;
  logic [N2-1:0]          a2_mis, b_mis;

  assign a0 = y1[W-1:0];
  assign b0 = y2[W-1:0];

  always_comb begin
    cp = '0;
    cp[N1*W-1:0] = y1[N1*W-1:0];
    voted = maj_vote(cp, N1, W);
  end

  for (genvar k = 0; k < N1; k++) begin : g_y1
    assign a1_mis[k] = (y1[k*W +: W] != a0);
  end

  for (genvar k = 0; k < N2; k++) begin : g_y2
    assign a2_mis[k] = (y2[(2*k+1)*W +: W] != a0);
    assign b_mis[k]  = (y2[2*k*W +: W] != b0);
  end

  assign a       = voted[W-1:0];
  assign b       = b0;
  assign a_err   = (|a1_mis) || (|a2_mis);
  assign b_err   = |b_mis;
  // Anything above the replicated region must be zero.
  assign pad_err = (|(y1 >> (N1*W))) || (|(y2 >> (N2*2*W)));
endmodule

// File: rtl/replication_unpacker.sv
// Two-stage valid/ready unpacker: S1 holds the raw word, S2 holds the decode plus error status.
module replication_unpacker #(
  parameter int W     = replication_pkg::W,
  parameter int N1    = replication_pkg::N1,
  parameter int N2    = replication_pkg::N2,
  parameter int Y1W   = replication_pkg::Y1W,
  parameter int Y2W   = replication_pkg::Y2W,
  parameter int CNT_W = replication_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Y1W-1:0]   y1_in,
  input  logic [Y2W-1:0]   y2_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic             a_err,
  output logic             b_err,
  output logic             pad_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         a_err;
    logic         b_err;
    logic         pad_err;
  } dec_t;

  logic [STAGES:1] vld_pipe;
  logic            rdy_en;
  logic [Y1W-1:0]  s1_y1;
  logic [Y2W-1:0]  s1_y2;
  dec_t            dec, s2;
  logic            s1_adv, s2_adv, in_xfer, s2_load, flagged;

  replica_check #(.W(W), .N1(N1), .N2(N2), .Y1W(Y1W), .Y2W(Y2W)) u_check (
    .y1      (s1_y1),
    .y2      (s1_y2),
    .a       (dec.a),
    .b       (dec.b),
    .a_err   (dec.a_err),
    .b_err   (dec.b_err),
    .pad_err (dec.pad_err)
  );

  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign s1_adv   = !vld_pipe[1] || s2_adv;
  // rdy_en keeps in_ready low through reset and raises it on the first edge after release.
  assign in_ready = rdy_en && s1_adv;
  assign in_xfer  = in_valid && in_ready;
  assign s2_load  = vld_pipe[1] && s2_adv;
  assign flagged  = dec.a_err || dec.b_err || dec.pad_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_en     <= 1'b0;
      vld_pipe   <= '0;
      s1_y1      <= '0;
      s1_y2      <= '0;
      s2         <= '0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (s1_adv) begin
        vld_pipe[1] <= in_xfer;
        if (in_xfer) begin
          s1_y1 <= y1_in;
          s1_y2 <= y2_in;
        end
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2 <= dec;
      end
      // A clear on the same edge as a flagged load wins; that word is not counted.
      if (clr_err) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end else if (s2_load && flagged) begin
        err_sticky <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

  assign out_valid = vld_pipe[2];
  assign a_out     = s2.a;
  assign b_out     = s2.b;
  assign a_err     = s2.a_err;
  assign b_err     = s2.b_err;
  assign pad_err   = s2.pad_err;
endmodule
